// File: rtl/car_node_snapshot.sv
// car_node_snapshot: ping-pong snapshot of car node streams for display, with
// per-stream write counters and a 1-cycle registered read port.
// Optional feature macro: CAR_CAMERA_FOLLOW_EN (camera subtracts body centre of mass).
`default_nettype none

module car_node_snapshot #(
    parameter int NUM_WHEEL_NODES = 4,
    parameter int NUM_BODY_NODES  = 4,
    parameter int POSITION_SIZE   = 16,
    parameter int SCREEN_CX       = 512,
    parameter int SCREEN_CY       = 384,
    localparam int MAX_NODES = (NUM_WHEEL_NODES > NUM_BODY_NODES) ? NUM_WHEEL_NODES : NUM_BODY_NODES,
    localparam int IDX_W     = $clog2(MAX_NODES) + 1
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic signed [POSITION_SIZE-1:0] left_wheel_x,
    input  logic signed [POSITION_SIZE-1:0] left_wheel_y,
    input  logic                            left_wheel_valid,
    input  logic signed [POSITION_SIZE-1:0] right_wheel_x,
    input  logic signed [POSITION_SIZE-1:0] right_wheel_y,
    input  logic                            right_wheel_valid,
    input  logic signed [POSITION_SIZE-1:0] body_x,
    input  logic signed [POSITION_SIZE-1:0] body_y,
    input  logic                            body_valid,
    input  logic signed [POSITION_SIZE-1:0] com_x_in,
    input  logic signed [POSITION_SIZE-1:0] com_y_in,
    input  logic                            com_valid_in,
    input  logic                            all_done_in,
    input  logic                            frame_sync_in,
    input  logic [1:0]                      rd_sel,
    input  logic [IDX_W-1:0]                rd_idx,
    output logic signed [POSITION_SIZE-1:0] rd_x,
    output logic signed [POSITION_SIZE-1:0] rd_y,
    output logic                            rd_valid,
    output logic                            frame_swap,
    output logic [7:0]                      drop_count,
    output logic                            overflow
);

    localparam int P      = POSITION_SIZE;
    localparam int SLOT_W = IDX_W - 1;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_READY = 2'd1,
        ST_SKIP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               stream_active_q, stream_active_d;
    logic [7:0]         drop_count_q, drop_count_d;
    logic               frame_swap_q;
    logic               overflow_q;
    logic               wr_bank_q;
    logic [IDX_W-1:0]   wr_cnt_q [3];
    // Set index matches rd_sel: 0 left wheel, 1 right wheel, 2 body.
    logic signed [P-1:0] node_x_q [2][3][MAX_NODES];
    logic signed [P-1:0] node_y_q [2][3][MAX_NODES];
    logic                rd_valid_q;
    logic signed [P-1:0] rd_x_q, rd_y_q;

    logic [2:0]          w_valid;
    logic signed [P-1:0] w_in_x [3];
    logic signed [P-1:0] w_in_y [3];
    logic                w_swap;
    logic signed [P-1:0] w_cam_x, w_cam_y;
    logic                w_rd_ok;
    logic [1:0]          w_rd_set;
    logic signed [P-1:0] w_node_x, w_node_y;

    function automatic logic [IDX_W-1:0] set_limit(input logic [1:0] s);
        return (s == 2'd2) ? IDX_W'(NUM_BODY_NODES) : IDX_W'(NUM_WHEEL_NODES);
    endfunction

    assign w_valid = {body_valid, right_wheel_valid, left_wheel_valid};
    assign w_in_x  = '{left_wheel_x, right_wheel_x, body_x};
    assign w_in_y  = '{left_wheel_y, right_wheel_y, body_y};

    always_comb begin
        state_d         = state_q;
        stream_active_d = stream_active_q;
        drop_count_d    = drop_count_q;
        w_swap          = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (all_done_in) state_d = ST_READY;
            end
            ST_READY: begin
                if (all_done_in) begin
                    stream_active_d = 1'b0;
                    if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
                end else if (|w_valid) begin
                    stream_active_d = 1'b1;
                end
                // An update still streaming at swap time would land half-written; skip it.
                if (frame_sync_in) begin
                    w_swap          = 1'b1;
                    stream_active_d = 1'b0;
                    state_d = ((stream_active_q || (|w_valid)) && !all_done_in) ? ST_SKIP : ST_FILL;
                end
            end
            ST_SKIP: begin
                if (all_done_in) state_d = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q         <= ST_FILL;
            stream_active_q <= 1'b0;
            drop_count_q    <= 8'd0;
            frame_swap_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            stream_active_q <= stream_active_d;
            drop_count_q    <= drop_count_d;
            frame_swap_q    <= w_swap;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
            for (int s = 0; s < 3; s++) begin
                wr_cnt_q[s] <= '0;
                for (int b = 0; b < 2; b++) begin
                    for (int n = 0; n < MAX_NODES; n++) begin
                        node_x_q[b][s][n] <= '0;
                        node_y_q[b][s][n] <= '0;
                    end
                end
            end
        end else begin
            if (state_q == ST_FILL) begin
                for (int s = 0; s < 3; s++) begin
                    if (w_valid[s]) begin
                        if (wr_cnt_q[s] < set_limit(2'(s))) begin
                            node_x_q[wr_bank_q][s][wr_cnt_q[s][SLOT_W-1:0]] <= w_in_x[s];
                            node_y_q[wr_bank_q][s][wr_cnt_q[s][SLOT_W-1:0]] <= w_in_y[s];
                            wr_cnt_q[s] <= wr_cnt_q[s] + IDX_W'(1);
                        end else begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
            end
            if (w_swap) wr_bank_q <= ~wr_bank_q;
            if (w_swap || (state_q == ST_SKIP && all_done_in)) begin
                for (int s = 0; s < 3; s++) wr_cnt_q[s] <= '0;
            end
        end
    end

`ifdef CAR_CAMERA_FOLLOW_EN
    logic signed [P-1:0] cam_pend_x_q, cam_pend_y_q;
    logic signed [P-1:0] cam_act_x_q, cam_act_y_q;

    // The swap copies the previously latched centre; a same-cycle com update waits for the next swap.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            cam_pend_x_q <= '0;
            cam_pend_y_q <= '0;
            cam_act_x_q  <= '0;
            cam_act_y_q  <= '0;
        end else begin
            if (w_swap) begin
                cam_act_x_q <= cam_pend_x_q;
                cam_act_y_q <= cam_pend_y_q;
            end
            if (com_valid_in) begin
                cam_pend_x_q <= com_x_in;
                cam_pend_y_q <= com_y_in;
            end
        end
    end

    assign w_cam_x = cam_act_x_q;
    assign w_cam_y = cam_act_y_q;
`else
    logic unused_com;
    assign unused_com = ^{com_x_in, com_y_in, com_valid_in};
    assign w_cam_x    = '0;
    assign w_cam_y    = '0;
`endif

    always_comb begin
        w_rd_set = (rd_sel == 2'd3) ? 2'd0 : rd_sel;
        w_rd_ok  = (rd_sel != 2'd3) && (rd_idx < set_limit(rd_sel));
        w_node_x = node_x_q[~wr_bank_q][w_rd_set][rd_idx[SLOT_W-1:0]];
        w_node_y = node_y_q[~wr_bank_q][w_rd_set][rd_idx[SLOT_W-1:0]];
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rd_valid_q <= 1'b0;
            rd_x_q     <= '0;
            rd_y_q     <= '0;
        end else begin
            rd_valid_q <= w_rd_ok;
            if (w_rd_ok) begin
                rd_x_q <= w_node_x - w_cam_x + P'(SCREEN_CX);
                rd_y_q <= w_node_y - w_cam_y + P'(SCREEN_CY);
            end
        end
    end

    assign rd_x       = rd_x_q;
    assign rd_y       = rd_y_q;
    assign rd_valid   = rd_valid_q;
    assign frame_swap = frame_swap_q;
    assign drop_count = drop_count_q;
    assign overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_car_node_snapshot.sv
// tb_car_node_snapshot: directed scenarios plus randomized traffic checked
// against a frame-level snapshot model of car_node_snapshot.
`default_nettype none

module tb_car_node_snapshot;

    localparam int NW   = 4;
    localparam int NB   = 4;
    localparam int P    = 16;
    localparam int IDXW = 3;
    localparam logic signed [P-1:0] SCX = 16'sd512;
    localparam logic signed [P-1:0] SCY = 16'sd384;
    localparam int M_FILL = 0, M_READY = 1, M_SKIP = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    logic signed [P-1:0] left_wheel_x, left_wheel_y, right_wheel_x, right_wheel_y;
    logic signed [P-1:0] body_x, body_y, com_x_in, com_y_in;
    logic left_wheel_valid, right_wheel_valid, body_valid, com_valid_in;
    logic all_done_in, frame_sync_in;
    logic [1:0] rd_sel;
    logic [IDXW-1:0] rd_idx;
    logic signed [P-1:0] rd_x, rd_y;
    logic rd_valid, frame_swap, overflow;
    logic [7:0] drop_count;

    always #5 clk_in = ~clk_in;

    car_node_snapshot #(
        .NUM_WHEEL_NODES(NW), .NUM_BODY_NODES(NB), .POSITION_SIZE(P),
        .SCREEN_CX(512), .SCREEN_CY(384)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .left_wheel_x(left_wheel_x), .left_wheel_y(left_wheel_y), .left_wheel_valid(left_wheel_valid),
        .right_wheel_x(right_wheel_x), .right_wheel_y(right_wheel_y), .right_wheel_valid(right_wheel_valid),
        .body_x(body_x), .body_y(body_y), .body_valid(body_valid),
        .com_x_in(com_x_in), .com_y_in(com_y_in), .com_valid_in(com_valid_in),
        .all_done_in(all_done_in), .frame_sync_in(frame_sync_in),
        .rd_sel(rd_sel), .rd_idx(rd_idx),
        .rd_x(rd_x), .rd_y(rd_y), .rd_valid(rd_valid),
        .frame_swap(frame_swap), .drop_count(drop_count), .overflow(overflow)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frames of node snapshots, a display copy and a fill copy.
    logic signed [P-1:0] m_x [2][3][4];
    logic signed [P-1:0] m_y [2][3][4];
    int m_cnt [3];
    int m_mode, m_wr, m_drop;
    bit m_active, m_ovf;
    logic signed [P-1:0] m_pend_x, m_pend_y, m_cam_x, m_cam_y;
    logic signed [P-1:0] e_rx, e_ry;
    bit e_rv, e_sw;

    function automatic int lim(input int s);
        return (s == 2) ? NB : NW;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int s = 0; s < 3; s++)
                for (int n = 0; n < 4; n++) begin
                    m_x[b][s][n] = '0;
                    m_y[b][s][n] = '0;
                end
        for (int s = 0; s < 3; s++) m_cnt[s] = 0;
        m_mode = M_FILL; m_wr = 0; m_drop = 0; m_active = 0; m_ovf = 0;
        m_pend_x = '0; m_pend_y = '0; m_cam_x = '0; m_cam_y = '0;
        e_rx = '0; e_ry = '0; e_rv = 0; e_sw = 0;
    endtask

    task automatic model_step();
        bit v [3];
        logic signed [P-1:0] ix [3];
        logic signed [P-1:0] iy [3];
        bit anyv;
        int rb, s;
        v  = '{left_wheel_valid, right_wheel_valid, body_valid};
        ix = '{left_wheel_x, right_wheel_x, body_x};
        iy = '{left_wheel_y, right_wheel_y, body_y};
        anyv = v[0] | v[1] | v[2];
        rb = 1 - m_wr;
        s  = int'(rd_sel);
        if (s < 3 && int'(rd_idx) < lim(s)) begin
            e_rv = 1;
            e_rx = m_x[rb][s][rd_idx] - m_cam_x + SCX;
            e_ry = m_y[rb][s][rd_idx] - m_cam_y + SCY;
        end else begin
            e_rv = 0;
        end
        e_sw = (m_mode == M_READY) && frame_sync_in;
        case (m_mode)
            M_FILL: begin
                for (int k = 0; k < 3; k++) begin
                    if (v[k]) begin
                        if (m_cnt[k] < lim(k)) begin
                            m_x[m_wr][k][m_cnt[k]] = ix[k];
                            m_y[m_wr][k][m_cnt[k]] = iy[k];
                            m_cnt[k]++;
                        end else begin
                            m_ovf = 1;
                        end
                    end
                end
                if (all_done_in) m_mode = M_READY;
            end
            M_READY: begin
                bit was_active;
                was_active = m_active;
                if (all_done_in) begin
                    m_active = 0;
                    if (m_drop < 255) m_drop++;
                end else if (anyv) begin
                    m_active = 1;
                end
                if (frame_sync_in) begin
                    m_wr = 1 - m_wr;
                    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
                    m_cam_x = m_pend_x;
                    m_cam_y = m_pend_y;
                    m_mode = ((was_active || anyv) && !all_done_in) ? M_SKIP : M_FILL;
                    m_active = 0;
                end
            end
            default: begin
                if (all_done_in) begin
                    m_mode = M_FILL;
                    for (int k = 0; k < 3; k++) m_cnt[k] = 0;
                end
            end
        endcase
`ifdef CAR_CAMERA_FOLLOW_EN
        if (com_valid_in) begin
            m_pend_x = com_x_in;
            m_pend_y = com_y_in;
        end
`endif
    endtask

    task automatic clear_inputs();
        left_wheel_valid = 0; right_wheel_valid = 0; body_valid = 0; com_valid_in = 0;
        left_wheel_x = '0; left_wheel_y = '0; right_wheel_x = '0; right_wheel_y = '0;
        body_x = '0; body_y = '0; com_x_in = '0; com_y_in = '0;
        all_done_in = 0; frame_sync_in = 0;
        rd_sel = 2'd3; rd_idx = '0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_in);
        #1;
        check_eq("rd_valid", {31'd0, rd_valid}, {31'd0, e_rv});
        check_eq("rd_x", 32'(rd_x), 32'(e_rx));
        check_eq("rd_y", 32'(rd_y), 32'(e_ry));
        check_eq("frame_swap", {31'd0, frame_swap}, {31'd0, e_sw});
        check_eq("drop_count", {24'd0, drop_count}, 32'(m_drop));
        check_eq("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        clear_inputs();
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst_in = 1;
        #1;
        check_eq("rst_rd_x", 32'(rd_x), 32'd0);
        check_eq("rst_rd_y", 32'(rd_y), 32'd0);
        check_eq("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check_eq("rst_frame_swap", {31'd0, frame_swap}, 32'd0);
        check_eq("rst_drop_count", {24'd0, drop_count}, 32'd0);
        check_eq("rst_overflow", {31'd0, overflow}, 32'd0);
        model_reset();
        clear_inputs();
        @(posedge clk_in);
        #1;
        rst_in = 0;
    endtask

    initial begin
        logic signed [P-1:0] exp_x, exp_y;
        clear_inputs();
        model_reset();
        #2;
        do_reset();

        // Four body nodes, centre of mass, then publish and read body[1].
        for (int i = 0; i < 4; i++) begin
            body_valid = 1; body_x = 16'(10 + 40 * i / 2); body_y = 16'(20 + 20 * i);
            body_x = 16'(10 + 20 * i);
            tick();
        end
        com_valid_in = 1; com_x_in = 16'sd40; com_y_in = 16'sd50; tick();
        all_done_in = 1; tick();
        frame_sync_in = 1; tick();
        check_eq("swap_pulse", {31'd0, frame_swap}, 32'd1);
        rd_sel = 2'd2; rd_idx = 3'd1; tick();
`ifdef CAR_CAMERA_FOLLOW_EN
        exp_x = 16'sd502; exp_y = 16'sd374;
`else
        exp_x = 16'sd542; exp_y = 16'sd424;
`endif
        check_eq("body1_x", 32'(rd_x), 32'(exp_x));
        check_eq("body1_y", 32'(rd_y), 32'(exp_y));
        check_eq("body1_valid", {31'd0, rd_valid}, 32'd1);

        // Two undisplayed updates while waiting for vblank.
        all_done_in = 1; tick();
        all_done_in = 1; tick();
        all_done_in = 1; tick();
        check_eq("drop_two", {24'd0, drop_count}, 32'd2);
        frame_sync_in = 1; tick();
        check_eq("swap_once", {31'd0, frame_swap}, 32'd1);
        tick();
        check_eq("swap_once_end", {31'd0, frame_swap}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            left_wheel_valid = 1; left_wheel_x = 16'(100 + i); left_wheel_y = 16'(-5 - i); tick();
        end
        all_done_in = 1; tick();
        frame_sync_in = 1; tick();
        rd_sel = 2'd0; rd_idx = 3'd3; tick();

        // Vblank lands mid-stream in READY: that update is skipped.
        all_done_in = 1; tick();
        for (int i = 0; i < 2; i++) begin body_valid = 1; body_x = 16'(900 + i); body_y = 16'(i); tick(); end
        frame_sync_in = 1; tick();
        for (int i = 0; i < 2; i++) begin body_valid = 1; body_x = 16'(950 + i); body_y = 16'(i); tick(); end
        all_done_in = 1; tick();
        body_valid = 1; body_x = 16'sd77; body_y = 16'sd88; tick();
        all_done_in = 1; tick();
        frame_sync_in = 1; tick();
        rd_sel = 2'd2; rd_idx = 3'd0; tick();

        // Valid, done and vblank together in FILL: node kept, swap deferred.
        left_wheel_valid = 1; left_wheel_x = 16'sd7; left_wheel_y = 16'sd9;
        all_done_in = 1; frame_sync_in = 1; tick();
        check_eq("no_swap_in_fill", {31'd0, frame_swap}, 32'd0);
        frame_sync_in = 1; tick();
        rd_sel = 2'd0; rd_idx = 3'd0; tick();

        // Overflow on the fifth left-wheel node.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            left_wheel_valid = 1; left_wheel_x = 16'(i); left_wheel_y = 16'(i); tick();
        end
        check_eq("overflow_set", {31'd0, overflow}, 32'd1);
        rd_sel = 2'd0; rd_idx = 3'd4; tick();
        check_eq("idx4_invalid", {31'd0, rd_valid}, 32'd0);

        // Reset mid-fill after two writes.
        do_reset();
        for (int i = 0; i < 2; i++) begin
            left_wheel_valid = 1; left_wheel_x = 16'(33 + i); left_wheel_y = 16'(44); tick();
        end
        #2;
        do_reset();
        rd_sel = 2'd0; rd_idx = 3'd0; tick();
        check_eq("post_rst_x", 32'(rd_x), 32'd512);
        check_eq("post_rst_y", 32'(rd_y), 32'd384);
        check_eq("post_rst_valid", {31'd0, rd_valid}, 32'd1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            left_wheel_valid  = ($urandom_range(0, 9) < 4);
            right_wheel_valid = ($urandom_range(0, 9) < 4);
            body_valid        = ($urandom_range(0, 9) < 4);
            left_wheel_x = 16'($urandom); left_wheel_y = 16'($urandom);
            right_wheel_x = 16'($urandom); right_wheel_y = 16'($urandom);
            body_x = 16'($urandom); body_y = 16'($urandom);
            com_valid_in = ($urandom_range(0, 9) == 0);
            com_x_in = 16'($urandom); com_y_in = 16'($urandom);
            r = int'($urandom_range(0, 15));
            all_done_in   = (r == 0);
            frame_sync_in = (r == 1);
            rd_sel = 2'($urandom_range(0, 3));
            rd_idx = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 699) == 0) begin
                clear_inputs();
                do_reset();
            end else begin
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
